// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin bus multiplexer.
// Holds the default channel count and data width, the output-register state type,
// and small index helpers used by rr_arbiter and rr_bus_mux.
// Optional feature macro: RR_MUX_PKT_LOCK_EN (packet locking). It is consumed by the
// arbiter and the top, not by this package.
package rr_mux_pkg;

  localparam int unsigned NumChDefault = 8;
  localparam int unsigned DataWDefault = 8;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } out_state_e;

  // Index width that never collapses to zero bits, even for tiny channel counts.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Increment modulo n; the wrap is explicit so non-power-of-two n works.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with rotating priority pointer.
// Ports:
//   clk_i, rst_ni  clock and synchronous active-low reset
//   req_i          per-channel request (the channel valids)
//   last_i         per-channel end-of-packet flag (only with RR_MUX_PKT_LOCK_EN)
//   load_ok_i      downstream register can take a beat this cycle
//   gnt_oh_o       one-hot grant (zero when nothing requests)
//   gnt_idx_o      index of the granted channel
//   gnt_valid_o    a grant exists this cycle
// Macro RR_MUX_PKT_LOCK_EN: once a beat without last is taken from a channel, the grant
// stays pinned to that channel until its last beat is taken.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned NumCh = NumChDefault,
  localparam int unsigned SelW = clog2_min1(NumCh)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] req_i,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [NumCh-1:0] last_i,
`endif
  input  logic             load_ok_i,
  output logic [NumCh-1:0] gnt_oh_o,
  output logic [SelW-1:0]  gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [SelW-1:0] ptr_q, ptr_d;
  logic [SelW-1:0] cand;
  logic [SelW-1:0] search_idx;
  logic            found;
  logic            xfer;

`ifdef RR_MUX_PKT_LOCK_EN
  logic            lock_q, lock_d;
  logic [SelW-1:0] lock_ch_q, lock_ch_d;
`endif

  // Walk the requests starting at ptr_q, wrapping at NumCh-1; first hit wins.
  always_comb begin
    found      = 1'b0;
    search_idx = '0;
    cand       = ptr_q;
    for (int i = 0; i < int'(NumCh); i++) begin
      if (!found && req_i[cand]) begin
        found      = 1'b1;
        search_idx = cand;
      end
      cand = SelW'(wrap_inc(32'(cand), NumCh));
    end
  end

  always_comb begin
    gnt_idx_o   = search_idx;
    gnt_valid_o = found;
`ifdef RR_MUX_PKT_LOCK_EN
    // A locked channel that drops valid stalls everyone rather than yielding.
    if (lock_q) begin
      gnt_idx_o   = lock_ch_q;
      gnt_valid_o = req_i[lock_ch_q];
    end
`endif
  end

  assign gnt_oh_o = gnt_valid_o ? (NumCh'(1) << gnt_idx_o) : '0;
  assign xfer     = gnt_valid_o && load_ok_i;

  always_comb begin
    ptr_d = ptr_q;
`ifdef RR_MUX_PKT_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      if (last_i[gnt_idx_o]) begin
        lock_d = 1'b0;
        ptr_d  = SelW'(wrap_inc(32'(gnt_idx_o), NumCh));
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = gnt_idx_o;
      end
    end
`else
    if (xfer) begin
      ptr_d = SelW'(wrap_inc(32'(gnt_idx_o), NumCh));
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      ptr_q     <= ptr_d;
`ifdef RR_MUX_PKT_LOCK_EN
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// N-channel valid/ready bus multiplexer with round-robin arbitration and a registered
// output stage (one cycle latency, one beat per cycle sustained).
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   in_valid     per-channel valid
//   in_data      packed channel buses, channel i at [i*DATA_W +: DATA_W]
//   in_last      per-channel end-of-packet (only with RR_MUX_PKT_LOCK_EN)
//   in_ready     per-channel accept, one-hot or zero
//   out_valid    output register holds a beat
//   out_data     registered selected data
//   out_ch       channel index of out_data
//   out_ready    downstream accept
// Macro RR_MUX_PKT_LOCK_EN adds in_last and keeps a packet's beats contiguous.
module rr_bus_mux
  import rr_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = NumChDefault,
  parameter int unsigned DATA_W = DataWDefault,
  localparam int unsigned SEL_W = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
`endif
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic              load_ok;
  logic              xfer;
  logic [NUM_CH-1:0] gnt_oh;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  // The register can take a beat when empty or when its beat leaves this cycle.
  assign load_ok = (state_q == StEmpty) || out_ready;

  rr_arbiter #(
    .NumCh(NUM_CH)
  ) u_arb (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (in_valid),
`ifdef RR_MUX_PKT_LOCK_EN
    .last_i     (in_last),
`endif
    .load_ok_i  (load_ok),
    .gnt_oh_o   (gnt_oh),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid)
  );

  // Nothing is accepted while reset is asserted.
  assign in_ready = (rst_n && load_ok) ? gnt_oh : '0;
  assign xfer     = rst_n && load_ok && gnt_valid;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    if (xfer) begin
      state_d    = StFull;
      out_data_d = ch_data[gnt_idx];
      out_ch_d   = gnt_idx;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
